mult_seq_controller: RTL
========================

Name: mult_seq_controller

Overview:
- Control FSM that sequences the shift-add sequential multiplier datapath: load operands, conditional add, shift, iterate WIDTH times, signal completion.
- Consumes the single-cycle start pulse produced by the OneShot block. Drives the datapath enables and reads back the multiplier LSB/zero status.
- Owns the iteration counter. Holds no operand or product storage.

Parameters:
- WIDTH, 8, operand width in bits = number of shift-add iterations; legal range 2..32.
- CNT_W, $clog2(WIDTH), width of the iteration counter (derived localparam, not overridable).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  one-cycle start pulse from OneShot; sampled only in IDLE.
- multiplier_lsb  input  1  bit 0 of the datapath multiplier shift register.
- multiplier_zero  input  1  datapath multiplier register == 0; used only with the optional feature.
- load_en  output  1  load operands, clear accumulator (1 cycle).
- add_en  output  1  accumulator += multiplicand this cycle.
- shift_en  output  1  shift multiplicand left / multiplier right this cycle.
- busy  output  1  operation in progress (LOAD through DONE inclusive).
- done  output  1  one-cycle completion pulse.
- result_valid  output  1  product valid; level signal.
- iter_count  output  CNT_W  completed iterations, for debug.

Behaviour:
- Reset: clk-synchronous, active-high.
  - rst=1 at any edge forces state=IDLE, iter_count=0, result_valid=0.
  - All enables, busy and done are 0 while in reset. Reset mid-operation aborts with no done pulse.
- States: IDLE, LOAD, EVAL, SHIFT, DONE. Encoding is a package enum.
- IDLE:
  - start=1 -> LOAD. result_valid clears on the same edge.
  - start=0 -> stay in IDLE.
- LOAD:
  - load_en=1, busy=1, iter_count<=0.
  - -> EVAL.
- EVAL:
  - add_en = multiplier_lsb (Mealy output, combinational from input).
  - -> SHIFT.
- SHIFT:
  - shift_en=1, iter_count<=iter_count+1.
  - If iter_count==WIDTH-1 -> DONE, else -> EVAL.
- DONE:
  - done=1 for exactly one cycle, result_valid<=1.
  - -> IDLE.
- Latency: start sampled at edge t gives LOAD at cycle t+1, iterations at t+2..t+1+2*WIDTH, done high in cycle t+2+2*WIDTH (WIDTH=8: 18 cycles). Latency is fixed and independent of operand values.
- start while busy (any state other than IDLE) is ignored, not queued.
- start in the same cycle that DONE is entered is ignored. A start in the IDLE cycle after DONE is accepted.
- result_valid holds 1 from the DONE edge until the next accepted start or rst.
- load_en, add_en and shift_en are mutually exclusive; at most one is high in any cycle.
- iter_count never exceeds WIDTH-1 and never wraps within an operation.

Optional Feature:
- Macro: MULT_SEQ_EARLY_EXIT_EN.
- Defined: in EVAL, if multiplier_zero=1, go directly to DONE with add_en=0 and no further shifts. Latency becomes variable and shorter. iter_count freezes at its current value.
- Undefined: multiplier_zero is ignored and latency is always 2+2*WIDTH.

Decomposition:
- Package mult_pkg:
  - state_t enum (IDLE, LOAD, EVAL, SHIFT, DONE).
  - MULT_WIDTH_DEFAULT = 8.
  - Latency helper constant/function: 2+2*W.
- Sub-module mult_iter_counter:
  - Inputs: clr, inc. Output: terminal flag (count==WIDTH-1).
  - Synchronous rst, same polarity as the controller.

Test Plan:
- Reset mid-operation: rst=1 for 1 cycle during SHIFT of iteration 3 -> next cycle IDLE, busy=0, done never pulses, iter_count=0.
- 13x11, WIDTH=8: bench model shifts multiplier 0b00001011, giving LSB sequence 1,1,0,1,0,0,0,0.
  - Expect load_en once, add_en exactly 3 pulses (iterations 0,1,3), shift_en 8 pulses.
  - done exactly 18 cycles after the start edge; datapath product 143; result_valid=1 afterwards.
- Start held/re-pulsed while busy: pulses at cycles 5 and 10 after the first start -> ignored; exactly one done pulse.
- Back-to-back: start in the first IDLE cycle after done -> accepted, result_valid drops to 0 that edge, second done 18 cycles later.
- Zero multiplier (0xFF x 0x00):
  - Macro undefined: done at 18 cycles, 0 add_en pulses.
  - MULT_SEQ_EARLY_EXIT_EN defined: done 3 cycles after start (LOAD, EVAL, DONE), 0 shift_en pulses.

Source files
------------

// File: rtl/mult_pkg.sv
// mult_pkg: shared FSM state encoding, default width and latency helper for the shift-add multiplier sequencer
package mult_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        EVAL,
        SHIFT,
        DONE
    } state_t;

    localparam int MULT_WIDTH_DEFAULT = 8;

    // Fixed start-edge-to-done latency in cycles for a W-bit operation without early exit
    function automatic int mult_latency(input int w);
        return 2 + 2 * w;
    endfunction

endpackage

// File: rtl/mult_iter_counter.sv
// mult_iter_counter: shift-add iteration counter with clear, increment and terminal (count == WIDTH-1) flag
module mult_iter_counter #(
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o,
    output logic             term_o
);

    logic [CNT_W-1:0] count_q;

    // Count completed iterations; clear on load or reset
    always_ff @(posedge clk) begin
        if (rst || clr_i) count_q <= '0;
        else if (inc_i) count_q <= count_q + CNT_W'(1);
    end

    assign count_o = count_q;
    assign term_o  = count_q == CNT_W'(WIDTH - 1);

endmodule

// File: rtl/mult_seq_controller.sv
// mult_seq_controller: control FSM sequencing load / conditional add / shift for WIDTH iterations.
// Optional MULT_SEQ_EARLY_EXIT_EN: finish as soon as the multiplier register reaches zero.
module mult_seq_controller
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH_DEFAULT,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             multiplier_lsb,
    input  logic             multiplier_zero,
    output logic             load_en,
    output logic             add_en,
    output logic             shift_en,
    output logic             busy,
    output logic             done,
    output logic             result_valid,
    output logic [CNT_W-1:0] iter_count
);

    state_t state_q, state_d;
    logic   load_en_q, shift_en_q, busy_q, done_q, result_valid_q;
    logic   term, early_exit;

`ifdef MULT_SEQ_EARLY_EXIT_EN
    assign early_exit = multiplier_zero;
`else
    logic unused_zero;
    assign unused_zero = multiplier_zero;
    assign early_exit  = 1'b0;
`endif

    // The terminal shift does not increment, so the count saturates at WIDTH-1 instead of wrapping
    mult_iter_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (load_en_q),
        .inc_i   (shift_en_q && !term),
        .count_o (iter_count),
        .term_o  (term)
    );

    // Next-state: start only honoured in IDLE; EVAL alternates with SHIFT until the terminal iteration
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? LOAD : IDLE;
            LOAD:    state_d = EVAL;
            EVAL:    state_d = early_exit ? DONE : SHIFT;
            SHIFT:   state_d = term ? DONE : EVAL;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register with outputs decoded from the next state so they are registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            load_en_q      <= 1'b0;
            shift_en_q     <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            load_en_q      <= state_d == LOAD;
            shift_en_q     <= state_d == SHIFT;
            busy_q         <= state_d != IDLE;
            done_q         <= state_d == DONE;
            result_valid_q <= state_d == DONE ? 1'b1 : state_d == LOAD ? 1'b0 : result_valid_q;
        end
    end

    // Add is decided from the live multiplier LSB; suppressed on early exit and during reset
    assign add_en       = state_q == EVAL && multiplier_lsb && !early_exit && !rst;
    assign load_en      = load_en_q;
    assign shift_en     = shift_en_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign result_valid = result_valid_q;

endmodule
